pwm_level_decoder: RTL
======================

PWM_LEVEL_DECODER -- requirements
Module: pwm_level_decoder

Interface
REQ-001 Parameter TH1, default 150, minimum high-cycle count for level 1.
REQ-002 Parameter TH2, default 450, minimum high-cycle count for level 2.
REQ-003 Parameter TH3, default 700, minimum high-cycle count for level 3.
REQ-004 Parameter TH4, default 900, minimum high-cycle count for level 4.
REQ-005 Port i_clk, input, 1 bit: the single clock; every flop SHALL use its rising edge.
REQ-006 Port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port i_pwm, input, 1 bit: asynchronous PWM light signal; period is nominally 1000 clocks.
REQ-008 Port o_level, output, 3 bits: decoded brightness level, 0..4.
REQ-009 Port o_high, output, 10 bits: high-cycle count of the last measured period.
REQ-010 Port o_period, output, 10 bits: cycle count of the last measured period.
REQ-011 Port o_valid, output, 1 bit: one-cycle pulse; o_level, o_high and o_period are updated on this cycle.
REQ-012 Port o_error, output, 1 bit: sticky measurement-failure flag.

Function
REQ-013 Synchronizer: i_pwm SHALL pass through a 2-flop synchronizer; the synced signal is s_pwm.
REQ-014 Edge detect: a rising edge is a cycle where s_pwm=1 and the previous s_pwm=0.
REQ-015 FSM states SHALL be exactly IDLE and MEASURE.
REQ-016 IDLE on a rising edge: load period count=1 and high count=1, then go to MEASURE.
REQ-017 IDLE with no rising edge: increment a 10-bit idle counter; it clears on any rising edge.
REQ-018 MEASURE, each cycle without a rising edge: period count +1; high count +1 when s_pwm=1.
REQ-019 MEASURE, closing rising edge: register the counts to o_period/o_high and the decoded level to o_level, pulse o_valid on the next cycle, and clear o_error.
REQ-020 Back-to-back: the closing edge SHALL also be the opening edge of the next period (counts reload to 1, state stays MEASURE), so every period is measured with no gap.
REQ-021 Decode rule: H<TH1 gives 0; TH1<=H<TH2 gives 1; TH2<=H<TH3 gives 2; TH3<=H<TH4 gives 3; H>=TH4 gives 4. Compare unsigned, 10 bits.
REQ-022 Overflow: if the period count reaches 1023 in MEASURE with no closing edge, set o_error=1, go to IDLE, clear the idle counter, leave o_level/o_high/o_period unchanged and do not pulse o_valid.
REQ-023 Constant low: when the idle counter reaches 1023 with s_pwm=0, pulse o_valid with o_level=0, o_high=0, o_period=0; clear the idle counter and stay in IDLE.
REQ-024 Constant high: when the idle counter reaches 1023 with s_pwm=1, set o_error=1, clear the idle counter and stay in IDLE.
REQ-025 Simultaneous events: a rising edge SHALL take priority over an idle-counter terminal count on the same cycle.
REQ-026 Latency: an i_pwm rising edge SHALL produce o_valid exactly 3 cycles after the sampling clock (2 synchronizer cycles plus 1 output register cycle).
REQ-027 Counters SHALL never wrap; 1023 is terminal.

Reset
REQ-028 i_reset=1 SHALL force state IDLE, clear all counters and synchronizer flops, and hold o_level=0, o_high=0, o_period=0, o_valid=0, o_error=0.
REQ-029 Reset asserted mid-MEASURE SHALL discard the partial measurement; after release, the first o_valid requires two fresh rising edges.

Verification
REQ-030 Period 1000, high 300, 3 periods: o_valid every 1000 cycles; o_high=300, o_period=1000, o_level=1.
REQ-031 Sweep high=600, 800, 999 with period 1000: o_level=2, 3, 4; o_high matches exactly.
REQ-032 Boundary highs 149/150 and 899/900 with period 1000: o_level 0/1 and 3/4.
REQ-033 i_pwm held low for 1100 cycles after reset: one o_valid with o_level=0 and o_period=0; o_error=0.
REQ-034 One rising edge, then i_pwm low for 1100 cycles: o_error=1, no o_valid; the next two good edges give o_valid and o_error=0.
REQ-035 Reset asserted 500 cycles into a 1000-cycle period: outputs 0 during reset; the first o_valid follows the second post-reset edge with correct values.

Source files
------------

// File: rtl/pwm_level_decoder.sv
// Decodes a PWM light signal into a 0..4 brightness level by measuring high time
// and period over each rising-edge-to-rising-edge interval of the synchronized input.
module pwm_level_decoder #(
  parameter int unsigned TH1 = 150,
  parameter int unsigned TH2 = 450,
  parameter int unsigned TH3 = 700,
  parameter int unsigned TH4 = 900
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pwm,
  output logic [2:0] o_level,
  output logic [9:0] o_high,
  output logic [9:0] o_period,
  output logic       o_valid,
  output logic       o_error
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [9:0] CNT_MAX = '1;
  localparam logic [9:0] TH1_C   = 10'(TH1);
  localparam logic [9:0] TH2_C   = 10'(TH2);
  localparam logic [9:0] TH3_C   = 10'(TH3);
  localparam logic [9:0] TH4_C   = 10'(TH4);

  state_t     state, state_d;
  logic       sync_meta, s_pwm, s_pwm_q;
  logic       rise;
  logic [9:0] period_cnt, period_d;
  logic [9:0] high_cnt, high_d;
  logic [9:0] idle_cnt, idle_d;
  logic [2:0] level_d, decoded;
  logic [9:0] out_high_d, out_period_d;
  logic       valid_d, error_d;

  assign rise = s_pwm & ~s_pwm_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    decoded = 3'd0;
    if      (high_cnt >= TH4_C) decoded = 3'd4;
    else if (high_cnt >= TH3_C) decoded = 3'd3;
    else if (high_cnt >= TH2_C) decoded = 3'd2;
    else if (high_cnt >= TH1_C) decoded = 3'd1;
  end

  always_comb begin
    state_d      = state;
    period_d     = period_cnt;
    high_d       = high_cnt;
    idle_d       = idle_cnt;
    level_d      = o_level;
    out_high_d   = o_high;
    out_period_d = o_period;
    valid_d      = 1'b0;
    error_d      = o_error;

    if (rise) begin
      // A closing edge doubles as the opening edge of the next period.
      period_d = 10'd1;
      high_d   = 10'd1;
      idle_d   = '0;
      state_d  = MEASURE;
      if (state == MEASURE) begin
        level_d      = decoded;
        out_high_d   = high_cnt;
        out_period_d = period_cnt;
        valid_d      = 1'b1;
        error_d      = 1'b0;
      end
    end else if (state == MEASURE) begin
      if (period_cnt == CNT_MAX) begin
        error_d = 1'b1;
        state_d = IDLE;
        idle_d  = '0;
      end else begin
        period_d = period_cnt + 10'd1;
        if (s_pwm) high_d = high_cnt + 10'd1;
      end
    end else begin
      if (idle_cnt == CNT_MAX) begin
        idle_d = '0;
        if (s_pwm) begin
          error_d = 1'b1;
        end else begin
          valid_d      = 1'b1;
          level_d      = 3'd0;
          out_high_d   = '0;
          out_period_d = '0;
        end
      end else begin
        idle_d = idle_cnt + 10'd1;
      end
    end
  end

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      sync_meta  <= 1'b0;
      s_pwm      <= 1'b0;
      s_pwm_q    <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      idle_cnt   <= '0;
      o_level    <= '0;
      o_high     <= '0;
      o_period   <= '0;
      o_valid    <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state      <= state_d;
      sync_meta  <= i_pwm;
      s_pwm      <= sync_meta;
      s_pwm_q    <= s_pwm;
      period_cnt <= period_d;
      high_cnt   <= high_d;
      idle_cnt   <= idle_d;
      o_level    <= level_d;
      o_high     <= out_high_d;
      o_period   <= out_period_d;
      o_valid    <= valid_d;
      o_error    <= error_d;
    end
  end

endmodule
